// File: rtl/dispatch_pkg.sv
// Shared types and constants for the demux dispatch front end.
package dispatch_pkg;

    localparam int DW_DEF = 4;
    localparam int CH_W   = 2;
    localparam int DROP_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND  = 2'd1,
        STALL = 2'd2
    } state_e;

endpackage

// File: rtl/demux_dispatch_ctrl_if.sv
// Upstream handshake plus demux-facing head bus of the dispatch controller.
interface demux_dispatch_ctrl_if #(
    parameter int DW = 4
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [1:0]    in_dest;
    logic          in_ready;
    logic [3:0]    ch_ready;
    logic [DW-1:0] dmux_data;
    logic [1:0]    dmux_sel;
    logic          out_valid;

    modport slave (
        input  in_valid, in_data, in_dest, ch_ready,
        output in_ready, dmux_data, dmux_sel, out_valid
    );

    modport master (
        output in_valid, in_data, in_dest, ch_ready,
        input  in_ready, dmux_data, dmux_sel, out_valid
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; the caller never pushes when full.
module sync_fifo #(
    parameter  int WIDTH = 6,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;

    // Power-of-two depth lets the pointers wrap on plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry only matters while count says it is live.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Buffers tagged words and presents the head to the 1-to-4 demux when its channel is ready.
// Define DISPATCH_RR_EN to tag words round-robin instead of using in_dest.
module demux_dispatch_ctrl
    import dispatch_pkg::*;
#(
    parameter int DW      = DW_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    demux_dispatch_ctrl_if.slave bus,
    output logic [DROP_W-1:0] drop_cnt,
    output logic              drop_flag
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(TIMEOUT + 1);

    state_e             state_q, state_d;
    logic [SW-1:0]      stall_cnt_q, stall_cnt_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic               drop_flag_q, drop_flag_d;

    logic               push, pop, deliver, drop, words_left;
    logic               in_ready, out_valid;
    logic [DW-1:0]      dmux_data;
    logic [CH_W-1:0]    dmux_sel;
    logic [CH_W-1:0]    wr_tag;
    logic [CW-1:0]      count;
    logic [DW+CH_W-1:0] head_word;
    logic [DW-1:0]      head_data;
    logic [CH_W-1:0]    head_dest;

`ifdef DISPATCH_RR_EN
    logic [CH_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CH_W-1:0] unused_in_dest;

    assign unused_in_dest = bus.in_dest;

    always_comb rr_ptr_d = rr_ptr_q + CH_W'(push);

    always_ff @(posedge clk) begin
        if (!rst_n) rr_ptr_q <= '0;
        else        rr_ptr_q <= rr_ptr_d;
    end

    assign wr_tag = rr_ptr_q;
`else
    assign wr_tag = bus.in_dest;
`endif

    assign push = bus.in_valid && in_ready;
    assign pop  = deliver || drop;

    sync_fifo #(
        .WIDTH (DW + CH_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({wr_tag, bus.in_data}),
        .rdata (head_word),
        .count (count)
    );

    assign head_data = head_word[DW-1:0];
    assign head_dest = head_word[DW+CH_W-1:DW];

    // After popping the head, something is still buffered or arriving this edge.
    assign words_left = (count > CW'(1)) || push;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            stall_cnt_q <= '0;
            drop_cnt_q  <= '0;
            drop_flag_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            drop_flag_q <= drop_flag_d;
        end
    end

    // NOTE: every comb output gets a default first, so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        stall_cnt_d = stall_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        drop_flag_d = drop_flag_q;
        deliver     = 1'b0;
        drop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0 || push) state_d = SEND;
            end
            SEND, STALL: begin
                if (bus.ch_ready[head_dest]) begin
                    deliver     = 1'b1;
                    stall_cnt_d = '0;
                    state_d     = words_left ? SEND : IDLE;
                end else if (state_q == STALL && stall_cnt_q == SW'(TIMEOUT)) begin
                    drop        = 1'b1;
                    stall_cnt_d = '0;
                    drop_cnt_d  = drop_cnt_q + DROP_W'(1);
                    drop_flag_d = 1'b1;
                    state_d     = words_left ? SEND : IDLE;
                end else begin
                    stall_cnt_d = stall_cnt_q + SW'(1);
                    state_d     = STALL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Zero data while idle keeps every demux output low.
    always_comb begin
        in_ready  = (count != CW'(DEPTH));
        out_valid = (state_q != IDLE);
        dmux_data = out_valid ? head_data : '0;
        dmux_sel  = out_valid ? head_dest : '0;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.dmux_data = dmux_data;
    assign bus.dmux_sel  = dmux_sel;
    assign drop_cnt      = drop_cnt_q;
    assign drop_flag     = drop_flag_q;

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Self-checking bench for demux_dispatch_ctrl: directed table, corner sequences, random vs queue model.
module tb_demux_dispatch_ctrl;

    localparam int DW      = 4;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 8;
`ifdef DISPATCH_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] drop_cnt;
    logic       drop_flag;

    always #5 clk = ~clk;

    demux_dispatch_ctrl_if #(.DW(DW)) bus ();

    demux_dispatch_ctrl #(
        .DW      (DW),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .drop_cnt  (drop_cnt),
        .drop_flag (drop_flag)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: a queue of words, a stall counter and a drop tally.
    typedef struct {
        logic [3:0] data;
        logic [1:0] dest;
    } word_t;

    word_t m_q[$];
    int    m_stall = 0;
    int    m_drops = 0;
    bit    m_flag  = 0;
    int    m_rr    = 0;

    task automatic model_edge(input logic rv, input logic iv, input logic [3:0] d,
                              input logic [1:0] dst, input logic [3:0] cr);
        bit    can_push;
        word_t w;
        if (!rv) begin
            m_q.delete();
            m_stall = 0;
            m_drops = 0;
            m_flag  = 0;
            m_rr    = 0;
            return;
        end
        can_push = (m_q.size() < DEPTH);
        if (m_q.size() > 0) begin
            if (cr[m_q[0].dest]) begin
                void'(m_q.pop_front());
                m_stall = 0;
            end else if (m_stall == TIMEOUT) begin
                void'(m_q.pop_front());
                m_drops = (m_drops + 1) % 256;
                m_flag  = 1;
                m_stall = 0;
            end else begin
                m_stall++;
            end
        end
        if (iv && can_push) begin
            w.data = d;
            w.dest = RR ? 2'(m_rr) : dst;
            m_q.push_back(w);
            m_rr = (m_rr + 1) % 4;
        end
    endtask

    task automatic compare_model(input string tag);
        bit         ov;
        logic [1:0] sel;
        logic [3:0] dat;
        ov  = (m_q.size() > 0);
        sel = ov ? m_q[0].dest : 2'd0;
        dat = ov ? m_q[0].data : 4'd0;
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'(ov));
        check({tag, " dmux_sel"},  32'(bus.dmux_sel),  32'(sel));
        check({tag, " dmux_data"}, 32'(bus.dmux_data), 32'(dat));
        check({tag, " in_ready"},  32'(bus.in_ready),  32'(m_q.size() < DEPTH));
        check({tag, " drop_cnt"},  32'(drop_cnt),      32'(m_drops));
        check({tag, " drop_flag"}, 32'(drop_flag),     32'(m_flag));
    endtask

    // Drive inputs, clock one edge, advance the model, then sample 1 time unit later.
    task automatic step(input string tag, input logic rv, input logic iv, input logic [3:0] d,
                        input logic [1:0] dst, input logic [3:0] cr);
        rst_n        = rv;
        bus.in_valid = iv;
        bus.in_data  = d;
        bus.in_dest  = dst;
        bus.ch_ready = cr;
        @(posedge clk);
        model_edge(rv, iv, d, dst, cr);
        #1;
        compare_model(tag);
    endtask

    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic [1:0] dst;
        logic [3:0] cr;
        logic       e_ov;
        logic [1:0] e_sel;
        logic [3:0] e_data;
        logic       e_ir;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Basic delivery, then fill to full with a held fifth word, then drain.
        vecs[0]  = '{1'b1, 4'hA, 2'd2, 4'hF, 1'b1, (RR ? 2'd0 : 2'd2), 4'hA, 1'b1};
        vecs[1]  = '{1'b0, 4'h0, 2'd0, 4'hF, 1'b0, 2'd0,               4'h0, 1'b1};
        vecs[2]  = '{1'b1, 4'h1, 2'd0, 4'h0, 1'b1, (RR ? 2'd1 : 2'd0), 4'h1, 1'b1};
        vecs[3]  = '{1'b1, 4'h2, 2'd1, 4'h0, 1'b1, (RR ? 2'd1 : 2'd0), 4'h1, 1'b1};
        vecs[4]  = '{1'b1, 4'h3, 2'd2, 4'h0, 1'b1, (RR ? 2'd1 : 2'd0), 4'h1, 1'b1};
        vecs[5]  = '{1'b1, 4'h4, 2'd3, 4'h0, 1'b1, (RR ? 2'd1 : 2'd0), 4'h1, 1'b0};
        vecs[6]  = '{1'b1, 4'h5, 2'd0, 4'h0, 1'b1, (RR ? 2'd1 : 2'd0), 4'h1, 1'b0};
        vecs[7]  = '{1'b1, 4'h5, 2'd0, 4'h3, 1'b1, (RR ? 2'd2 : 2'd1), 4'h2, 1'b1};
        vecs[8]  = '{1'b1, 4'h5, 2'd0, 4'h0, 1'b1, (RR ? 2'd2 : 2'd1), 4'h2, 1'b0};
        vecs[9]  = '{1'b0, 4'h0, 2'd0, 4'hF, 1'b1, (RR ? 2'd3 : 2'd2), 4'h3, 1'b1};
        vecs[10] = '{1'b0, 4'h0, 2'd0, 4'hF, 1'b1, (RR ? 2'd0 : 2'd3), 4'h4, 1'b1};
        vecs[11] = '{1'b0, 4'h0, 2'd0, 4'hF, 1'b1, (RR ? 2'd1 : 2'd0), 4'h5, 1'b1};
        vecs[12] = '{1'b0, 4'h0, 2'd0, 4'hF, 1'b0, 2'd0,               4'h0, 1'b1};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_dest  = '0;
        bus.ch_ready = '0;

        step("reset", 1'b0, 1'b0, 4'h0, 2'd0, 4'h0);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset in_ready",  32'(bus.in_ready),  32'd1);

        for (int i = 0; i < 13; i++) begin
            step($sformatf("vec%0d", i), 1'b1, vecs[i].iv, vecs[i].d, vecs[i].dst, vecs[i].cr);
            check($sformatf("vec%0d ov", i),   32'(bus.out_valid), 32'(vecs[i].e_ov));
            check($sformatf("vec%0d sel", i),  32'(bus.dmux_sel),  32'(vecs[i].e_sel));
            check($sformatf("vec%0d data", i), 32'(bus.dmux_data), 32'(vecs[i].e_data));
            check($sformatf("vec%0d ir", i),   32'(bus.in_ready),  32'(vecs[i].e_ir));
        end

        // Timeout drop: head stalls for TIMEOUT edges, dropped on the next one.
        step("to_push0", 1'b1, 1'b1, 4'h7, 2'd1, 4'h0);
        step("to_push1", 1'b1, 1'b1, 4'h8, 2'd2, 4'h0);
        for (int i = 0; i < TIMEOUT - 1; i++) step("to_stall", 1'b1, 1'b0, 4'h0, 2'd0, 4'h0);
        check("to before drop_cnt", 32'(drop_cnt), 32'd0);
        check("to before data",     32'(bus.dmux_data), 32'h7);
        step("to_drop", 1'b1, 1'b0, 4'h0, 2'd0, 4'h0);
        check("to drop_cnt",  32'(drop_cnt),      32'd1);
        check("to drop_flag", 32'(drop_flag),     32'd1);
        check("to next data", 32'(bus.dmux_data), 32'h8);
        check("to next ov",   32'(bus.out_valid), 32'd1);

        // Deliver beats drop: ready rises on the cycle the stall count reaches TIMEOUT.
        for (int i = 0; i < TIMEOUT; i++) step("dbd_stall", 1'b1, 1'b0, 4'h0, 2'd0, 4'h0);
        check("dbd pre drop_cnt", 32'(drop_cnt),      32'd1);
        check("dbd pre ov",       32'(bus.out_valid), 32'd1);
        step("dbd_deliver", 1'b1, 1'b0, 4'h0, 2'd0, 4'hF);
        check("dbd drop_cnt", 32'(drop_cnt),      32'd1);
        check("dbd ov",       32'(bus.out_valid), 32'd0);

        // Reset mid-operation discards buffered words and clears the drop state.
        for (int i = 0; i < 3; i++) step("rm_push", 1'b1, 1'b1, 4'(i + 9), 2'(i), 4'h0);
        step("rm_reset", 1'b0, 1'b0, 4'h0, 2'd0, 4'h0);
        check("rm out_valid", 32'(bus.out_valid), 32'd0);
        check("rm in_ready",  32'(bus.in_ready),  32'd1);
        check("rm drop_cnt",  32'(drop_cnt),      32'd0);
        check("rm drop_flag", 32'(drop_flag),     32'd0);
        check("rm dmux_data", 32'(bus.dmux_data), 32'd0);
        step("rm_after", 1'b1, 1'b0, 4'h0, 2'd0, 4'hF);
        check("rm after ov", 32'(bus.out_valid), 32'd0);

        // Random traffic in phases of free, blocked and mixed channel readiness.
        begin
            int         mode;
            logic [3:0] cr;
            mode = 0;
            for (int i = 0; i < 600; i++) begin
                if (i % 24 == 0) mode = int'($urandom_range(0, 2));
                case (mode)
                    0:       cr = 4'($urandom);
                    1:       cr = 4'h0;
                    default: cr = 4'hF;
                endcase
                step("rand", ($urandom_range(0, 99) != 0), 1'($urandom), 4'($urandom),
                     2'($urandom), cr);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/demux_dispatch_ctrl.md
Name: demux_dispatch_ctrl

Overview:
Sequential front end for the 1-to-4, 4-bit demultiplexer stage. Accepts 4-bit words tagged with a 2-bit destination over a valid/ready handshake and buffers them in a small FIFO. Presents the FIFO head on dmux_data/dmux_sel only when the addressed channel is ready. Drops words whose channel stalls beyond a timeout and counts the drops.

Parameters:
DW, 4, data width; must equal the demux data width
DEPTH, 4, FIFO entries; power of two, minimum 2
TIMEOUT, 8, consecutive stall cycles before the head word is dropped; minimum 1

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  upstream word valid
in_data  input  DW  upstream word
in_dest  input  2  destination channel: 0=a, 1=b, 2=c, 3=d
in_ready  output  1  FIFO can accept a word
ch_ready  input  4  per-channel consumer ready; bit i is channel i
dmux_data  output  DW  drives the demux data input
dmux_sel  output  2  drives the demux selector
out_valid  output  1  dmux_data/dmux_sel carry a live word
drop_cnt  output  8  number of words dropped on timeout; wraps at 255
drop_flag  output  1  sticky; set on the first drop

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low. All state is updated only on the rising edge of clk.
- Reset (rst_n=0 at an edge):
  - FIFO is emptied; state goes to IDLE.
  - stall_cnt=0, drop_cnt=0, drop_flag=0.
  - Outputs after the edge: in_ready=1, out_valid=0, dmux_data=0, dmux_sel=0.
  - Reset mid-transfer discards all buffered words. Nothing is delivered in the reset cycle.
- Push: happens when in_valid && in_ready. in_ready = (count != DEPTH), from the registered count only.
  - No write bypass when full: a push and a pop in the same cycle with count==DEPTH is not possible.
- Head presentation:
  - out_valid = (state != IDLE).
  - dmux_data = out_valid ? head.data : 0; dmux_sel = out_valid ? head.dest : 0. Zero data keeps all four demux outputs at 0 when idle.
- Latency: a word pushed into an empty FIFO at edge k is presented in the cycle after edge k.
- Deliver: when out_valid && ch_ready[dmux_sel] at an edge, the head is popped and stall_cnt clears.
- FSM states and transitions:
  - IDLE -> SEND when count becomes nonzero.
  - SEND -> SEND on a deliver when words remain, including a simultaneous push.
  - SEND -> IDLE on a deliver with count==1 and no push.
  - SEND -> STALL when ch_ready[dmux_sel]=0; stall_cnt=1.
  - STALL -> SEND on a deliver, or back to IDLE under the same condition as SEND.
  - STALL with ch_ready low: stall_cnt increments. When stall_cnt==TIMEOUT at an edge with ch_ready still low:
    - the head is popped without delivery;
    - drop_cnt increments; drop_flag is set;
    - stall_cnt=0; next state is SEND if words remain, else IDLE.
- Simultaneous events:
  - A push and a pop (deliver or drop) in one cycle leave count unchanged.
  - A push into an empty FIFO in the same cycle a drop empties it is legal.
  - A ch_ready rise on the timeout cycle counts as a deliver; deliver beats drop.
- Pointers: read and write pointers wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- Ordering: words are delivered strictly in arrival order. There is no per-channel reordering, so a stalled head blocks all channels.

Optional Feature:
DISPATCH_RR_EN.
- Defined: in_dest is ignored. Each pushed word is tagged with a round-robin pointer rr_ptr (reset 0), which increments by 1 modulo 4 on every push.
- Undefined: the tag is in_dest. No rr_ptr register exists.

Decomposition:
- Shared package dispatch_pkg: DW default, channel index width (2), drop counter width (8), FSM state encoding (IDLE=0, SEND=1, STALL=2).
- One natural sub-module, sync_fifo: parameters DW+2 and DEPTH; ports clk, rst_n, push, pop, wdata, rdata, count. The controller FSM, stall/drop logic and the optional rr_ptr stay in the top module.

Test Plan:
- Reset mid-operation: push 3 words with all ch_ready=0, then rst_n=0 for one edge -> out_valid=0, in_ready=1, drop_cnt=0, dmux_data=0.
- Basic delivery: ch_ready=4'b1111, push (data 4'hA, dest 2) -> next cycle out_valid=1, dmux_sel=2, dmux_data=4'hA; popped at the following edge; state returns to IDLE.
- Full FIFO: ch_ready=0, push 5 words -> in_ready=0 after the 4th; the 5th is held upstream until ch_ready rises.
- Timeout drop: TIMEOUT=8, head dest=1, ch_ready[1]=0 -> 8 stall edges, then the head is dropped; drop_cnt=1, drop_flag=1; the next word is presented.
- Deliver beats drop: ch_ready[1] rises on the cycle stall_cnt==TIMEOUT -> word delivered; drop_cnt unchanged.
- DISPATCH_RR_EN: push 6 words, all with in_dest=3 -> dmux_sel sequence 0,1,2,3,0,1.
